tiger_trace_tx: RTL and testbench

//   Transmit side of the Tiger instruction-trace interface. Builds the delayed pc/ins/insValid

---
 rtl/tiger_trace_pkg.sv | 20 ++
 rtl/tiger_trace_fifo.sv | 57 +++++
 rtl/tiger_trace_tx.sv | 146 ++++++++++++++
 tb/tb_tiger_trace_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tiger_trace_pkg.sv
// Purpose: shared constants and the trace record layout for the Tiger trace transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Record grows a ts field when TRACE_TIMESTAMP_EN is defined.
package tiger_trace_pkg;

    localparam logic [31:0] START_PC_DEF  = 32'h0080_0000;
    localparam logic [31:0] FINISH_PC_DEF = 32'h0080_0004;

    // One retired instruction as seen by the drain logic; pc sits in the top bits.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/tiger_trace_fifo.sv
// Purpose: generic first-word-fall-through FIFO with simultaneous push/pop.
// Latency: a pushed word is visible on rdata the cycle after the push.
// Backpressure: push while full without a pop is dropped and flagged on drop.
module tiger_trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    // A pop frees the slot the same cycle, so a full FIFO can still accept a push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    // Storage, power-of-2 wrapping pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tiger_trace_tx.sv
// Purpose: Tiger trace TX - pc/ins delay taps, START/FINISH window counter, trace packetiser, dcache stuck alarm.
// Latency: record pushed two pipeline advances after fetch, visible on trace_* one cycle later (FWFT).
// Backpressure: trace_valid/trace_ready; full FIFO drops records and sets sticky trace_overflow. Option: TRACE_TIMESTAMP_EN.
module tiger_trace_tx
    import tiger_trace_pkg::*;
#(
    parameter logic [31:0] START_PC    = START_PC_DEF,
    parameter logic [31:0] FINISH_PC   = FINISH_PC_DEF,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          STUCK_LIMIT = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        iCacheStall,
    input  logic        dCacheStall,
    input  logic [31:0] pc,
    input  logic [31:0] ins,
    input  logic        insValid,
    output logic [31:0] pc_r,
    output logic [31:0] pc_rr,
    output logic [31:0] pc_rrr,
    output logic [31:0] ins_r,
    output logic [31:0] ins_rr,
    output logic        insValid_r,
    output logic        insValid_rr,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_ins,
`ifdef TRACE_TIMESTAMP_EN
    output logic [31:0] trace_ts,
`endif
    output logic        trace_overflow,
    output logic        run_active,
    output logic        run_done,
    output logic [63:0] cycle_count,
    output logic        stall_alarm
);

    logic             advance;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             drop;
    logic [15:0]      stall_cnt;
    trace_rec_t       wr_rec;
    trace_rec_t       rd_rec;
    logic [REC_W-1:0] rd_dat;

    assign advance = ~(iCacheStall | dCacheStall);

    // Delay taps for the debug monitor; frozen while either cache stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_r        <= '0;
            pc_rr       <= '0;
            pc_rrr      <= '0;
            ins_r       <= '0;
            ins_rr      <= '0;
            insValid_r  <= 1'b0;
            insValid_rr <= 1'b0;
        end else if (advance) begin
            pc_r        <= pc;
            pc_rr       <= pc_r;
            pc_rrr      <= pc_rr;
            ins_r       <= ins;
            ins_rr      <= ins_r;
            insValid_r  <= insValid;
            insValid_rr <= insValid_r;
        end
    end

    // Measurement window: opens once on START_PC, closes for good on FINISH_PC.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_active  <= 1'b0;
            run_done    <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (run_active) cycle_count <= cycle_count + 64'd1;
            if (run_active && pc == FINISH_PC) begin
                run_done   <= 1'b1;
                run_active <= 1'b0;
            end else if (!run_active && !run_done && pc == START_PC) begin
                run_active <= 1'b1;
            end
        end
    end

    // Capture looks at the two-deep tap so the record pairs pc with its own ins.
    assign push = advance & insValid_rr & (run_active | (pc_rr == START_PC)) & ~run_done;
    assign pop  = trace_valid & trace_ready;

    always_comb begin
        wr_rec     = '0;
        wr_rec.pc  = pc_rr;
        wr_rec.ins = ins_rr;
`ifdef TRACE_TIMESTAMP_EN
        wr_rec.ts  = cycle_count[31:0];
`endif
    end

    tiger_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (wr_rec),
        .pop     (pop),
        .rdata   (rd_dat),
        .full    (full),
        .empty   (empty),
        .drop    (drop)
    );

    assign rd_rec      = rd_dat;
    assign trace_valid = ~empty;
    assign trace_pc    = rd_rec.pc;
    assign trace_ins   = rd_rec.ins;
`ifdef TRACE_TIMESTAMP_EN
    assign trace_ts    = rd_rec.ts;
`endif

    // Sticky drop flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset_n)  trace_overflow <= 1'b0;
        else if (drop) trace_overflow <= 1'b1;
    end

    // Consecutive dcache stall cycles, saturating, cleared as soon as the stall ends.
    always_ff @(posedge clk) begin
        if (!reset_n)              stall_cnt <= '0;
        else if (!dCacheStall)     stall_cnt <= '0;
        else if (stall_cnt != '1)  stall_cnt <= stall_cnt + 16'd1;
    end

    assign stall_alarm = (stall_cnt >= 16'(STUCK_LIMIT));

    // full is only consumed inside the FIFO's drop logic.
    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_tiger_trace_tx.sv
// Purpose: directed self-checking bench for tiger_trace_tx (window, capture, FIFO, stall alarm, reset).
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: trace_ready driven per scenario to hold, drain, or push+pop a full FIFO.
module tb_tiger_trace_tx;
    import tiger_trace_pkg::*;

    localparam logic [31:0] IDLE_PC = 32'h0000_0F00;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        iCacheStall, dCacheStall;
    logic [31:0] pc, ins;
    logic        insValid;
    logic [31:0] pc_r, pc_rr, pc_rrr, ins_r, ins_rr;
    logic        insValid_r, insValid_rr;
    logic        trace_valid, trace_ready;
    logic [31:0] trace_pc, trace_ins;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] trace_ts;
`endif
    logic        trace_overflow, run_active, run_done, stall_alarm;
    logic [63:0] cycle_count;

    int n_chk = 0;
    int n_err = 0;

    tiger_trace_tx dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .iCacheStall    (iCacheStall),
        .dCacheStall    (dCacheStall),
        .pc             (pc),
        .ins            (ins),
        .insValid       (insValid),
        .pc_r           (pc_r),
        .pc_rr          (pc_rr),
        .pc_rrr         (pc_rrr),
        .ins_r          (ins_r),
        .ins_rr         (ins_rr),
        .insValid_r     (insValid_r),
        .insValid_rr    (insValid_rr),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_ins      (trace_ins),
`ifdef TRACE_TIMESTAMP_EN
        .trace_ts       (trace_ts),
`endif
        .trace_overflow (trace_overflow),
        .run_active     (run_active),
        .run_done       (run_done),
        .cycle_count    (cycle_count),
        .stall_alarm    (stall_alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction i of a stream: index 0 is START_PC, the rest stay clear of START/FINISH.
    function automatic logic [31:0] pc_of(input int i);
        return (i == 0) ? START_PC_DEF : 32'h0000_1000 + 32'(i) * 32'd4;
    endfunction

    function automatic logic [31:0] ins_of(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic step(input logic [31:0] p, input logic [31:0] i, input logic v);
        pc = p; ins = i; insValid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(IDLE_PC, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; iCacheStall = 1'b0; dCacheStall = 1'b0; trace_ready = 1'b0;
        idle(2);
        reset_n = 1'b1;
    endtask

    // Pop n records with trace_ready high, expecting stream entries first..first+n-1.
    task automatic drain(input int first, input int n, input string tag);
        trace_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_vld"}, 64'(trace_valid), 64'd1);
            chk({tag, "_pc"},  64'(trace_pc),    64'(pc_of(first + k)));
            chk({tag, "_ins"}, 64'(trace_ins),   64'(ins_of(first + k)));
            idle(1);
        end
        trace_ready = 1'b0;
        chk({tag, "_empty"}, 64'(trace_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        pc = '0; ins = '0; insValid = 1'b0;
        do_reset();

        // Reset state
        chk("rst_valid",   64'(trace_valid),    64'd0);
        chk("rst_active",  64'(run_active),     64'd0);
        chk("rst_done",    64'(run_done),       64'd0);
        chk("rst_count",   cycle_count,         64'd0);
        chk("rst_ovf",     64'(trace_overflow), 64'd0);
        chk("rst_alarm",   64'(stall_alarm),    64'd0);
        chk("rst_pc_r",    64'(pc_r),           64'd0);

        // Delay chain holds on stall, shifts on advance
        step(32'h11, 32'h111, 1'b1);
        step(32'h22, 32'h222, 1'b1);
        iCacheStall = 1'b1;
        step(32'h33, 32'h333, 1'b0);
        chk("hold_pc_r",   64'(pc_r),       64'h22);
        chk("hold_pc_rr",  64'(pc_rr),      64'h11);
        chk("hold_vld_r",  64'(insValid_r), 64'd1);
        iCacheStall = 1'b0;
        step(32'h44, 32'h444, 1'b0);
        chk("adv_pc_r",    64'(pc_r),        64'h44);
        chk("adv_pc_rr",   64'(pc_rr),       64'h22);
        chk("adv_pc_rrr",  64'(pc_rrr),      64'h11);
        chk("adv_ins_rr",  64'(ins_rr),      64'h222);
        chk("adv_vld_r",   64'(insValid_r),  64'd0);
        chk("adv_vld_rr",  64'(insValid_rr), 64'd1);
        chk("adv_notrace", 64'(trace_valid), 64'd0);

        // 1: five instructions from START_PC drained in order
        do_reset();
        trace_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            step((c < 5) ? pc_of(c) : IDLE_PC, ins_of(c), c < 5);
            if (trace_valid && idx < 5) begin
                chk("t1_pc",  64'(trace_pc),  64'(pc_of(idx)));
                chk("t1_ins", 64'(trace_ins), 64'(ins_of(idx)));
`ifdef TRACE_TIMESTAMP_EN
                // window opens on edge 0, first push at edge 2 sees count 1
                chk("t7_ts",  64'(trace_ts),  64'(idx + 1));
`endif
                idx++;
            end
        end
        chk("t1_nrec", 64'(idx), 64'd5);
        trace_ready = 1'b0;

        // 2: dcache stall alarm at exactly 1000 cycles
        do_reset();
        dCacheStall = 1'b1;
        idle(999);
        chk("t2_alarm_999",  64'(stall_alarm), 64'd0);
        idle(1);
        chk("t2_alarm_1000", 64'(stall_alarm), 64'd1);
        dCacheStall = 1'b0;
        idle(1);
        chk("t2_alarm_drop", 64'(stall_alarm), 64'd0);

        // 3: 20 records into depth 16 with no consumer
        do_reset();
        for (int c = 0; c < 22; c++)
            step((c < 20) ? pc_of(c) : IDLE_PC, ins_of(c), c < 20);
        chk("t3_ovf",   64'(trace_overflow), 64'd1);
        drain(0, 16, "t3");

        // 4: window counter and sticky done
        do_reset();
        step(FINISH_PC_DEF, 32'h0, 1'b0);
        chk("t4_early_fin", 64'(run_done), 64'd0);
        step(START_PC_DEF, 32'h0, 1'b0);
        chk("t4_active", 64'(run_active), 64'd1);
        idle(9);
        step(FINISH_PC_DEF, 32'h0, 1'b0);
        chk("t4_done",   64'(run_done),   64'd1);
        chk("t4_inact",  64'(run_active), 64'd0);
        chk("t4_count",  cycle_count,     64'd10);
        step(START_PC_DEF, 32'h0, 1'b0);
        idle(3);
        chk("t4_restart_active", 64'(run_active), 64'd0);
        chk("t4_restart_count",  cycle_count,     64'd10);

        // 5: full FIFO, push and pop on the same edge (edge 18 carries push #16)
        do_reset();
        for (int c = 0; c < 20; c++) begin
            trace_ready = (c == 18);
            step((c <= 16) ? pc_of(c) : IDLE_PC, ins_of(c), c <= 16);
        end
        trace_ready = 1'b0;
        chk("t5_ovf", 64'(trace_overflow), 64'd0);
        drain(1, 16, "t5");

        // 6: reset with 8 records queued
        do_reset();
        for (int c = 0; c < 10; c++)
            step((c < 8) ? pc_of(c) : IDLE_PC, ins_of(c), c < 8);
        chk("t6_pre_vld",    64'(trace_valid), 64'd1);
        chk("t6_pre_active", 64'(run_active),  64'd1);
        reset_n = 1'b0;
        idle(1);
        chk("t6_vld",    64'(trace_valid), 64'd0);
        chk("t6_count",  cycle_count,      64'd0);
        chk("t6_active", 64'(run_active),  64'd0);
        chk("t6_pc_r",   64'(pc_r),        64'd0);
        reset_n = 1'b1;
        idle(2);
        chk("t6_post_vld", 64'(trace_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
